// File: rtl/can_frame_stimulus.sv
// can_frame_stimulus: serialises a CAN frame vector onto rx_bit with sample strobes and optional bit stuffing
module can_frame_stimulus #(
  parameter int MAX_FRAME_LEN = 512,
  parameter int LEN_W         = 10,
  parameter int CLKS_PER_BIT  = 10,
  parameter int SAMPLE_CLK    = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [MAX_FRAME_LEN-1:0] frame_bits,
  input  logic [LEN_W-1:0]         num_bits,
  input  logic                     stuff_en,
  input  logic [LEN_W-1:0]         stuff_len,
  output logic                     rx_bit,
  output logic                     sample_point,
  output logic                     busy,
  output logic                     done,
  output logic [LEN_W-1:0]         bits_sent,
  output logic [LEN_W-1:0]         stuff_inserted
);
  localparam int TQ_W = $clog2(CLKS_PER_BIT);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_LEN);
  localparam logic [MAX_FRAME_LEN-1:0] ONE = MAX_FRAME_LEN'(1);
  typedef enum logic [2:0] {IDLE, WAIT_BND, SEND, STUFF, FINISH} state_t;
  state_t state, state_n;
  logic [TQ_W-1:0] tq;
  logic [MAX_FRAME_LEN-1:0] fb_q;
  logic [LEN_W-1:0] nb_q, sl_q, bs_n, si_n;
  logic [2:0] run, run_n;
  logic se_q, rx_n, bnd, cur_bit, in_region;
  assign bnd = tq == TQ_W'(CLKS_PER_BIT - 1);
  assign cur_bit = |(fb_q & (ONE << (nb_q - bits_sent - 1'b1)));
  assign in_region = se_q && bits_sent < sl_q;
  assign busy = state == WAIT_BND || state == SEND || state == STUFF;
  assign done = state == FINISH;
  // bit timer, sample strobe, FSM state and line/counter registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      tq <= '0;
      sample_point <= 1'b0;
      state <= IDLE;
      rx_bit <= 1'b1;
      bits_sent <= '0;
      stuff_inserted <= '0;
      run <= '0;
    end else begin
      tq <= bnd ? '0 : tq + 1'b1;
      sample_point <= tq == TQ_W'(SAMPLE_CLK - 1);
      state <= state_n;
      rx_bit <= rx_n;
      bits_sent <= bs_n;
      stuff_inserted <= si_n;
      run <= run_n;
    end
  end
  // capture the frame request when a start is accepted, clamping oversize lengths
  always_ff @(posedge clock) begin
    if (state == IDLE && start) begin
      fb_q <= frame_bits;
      nb_q <= num_bits > MAX_LEN ? MAX_LEN : num_bits;
      sl_q <= stuff_len > MAX_LEN ? MAX_LEN : stuff_len;
      se_q <= stuff_en;
    end
  end
  // next slot selection at each boundary: stuff bit has priority over the end of frame
  always_comb begin
    state_n = state;
    rx_n = rx_bit;
    bs_n = bits_sent;
    si_n = stuff_inserted;
    run_n = run;
    if (state == IDLE && start) begin
      state_n = WAIT_BND;
      bs_n = '0;
      si_n = '0;
      run_n = '0;
    end else if (state == FINISH) begin
      state_n = IDLE;
    end else if (busy && bnd) begin
      if (run == 3'd5) begin
        state_n = STUFF;
        rx_n = !rx_bit;
        si_n = stuff_inserted + 1'b1;
        run_n = 3'd1;
      end else if (bits_sent == nb_q) begin
        state_n = FINISH;
        rx_n = 1'b1;
      end else begin
        state_n = SEND;
        rx_n = cur_bit;
        bs_n = bits_sent + 1'b1;
        run_n = !in_region ? 3'd0 : (run != 3'd0 && cur_bit == rx_bit) ? run + 3'd1 : 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_can_frame_stimulus.sv
// tb_can_frame_stimulus: randomized and directed checks of can_frame_stimulus against a slot-queue model
module tb_can_frame_stimulus;
  localparam int MFL = 512, LW = 10, CPB = 10, SC = 7;
  logic clock = 0, reset = 0, start = 0, stuff_en = 0;
  logic [MFL-1:0] frame_bits = '0;
  logic [LW-1:0] num_bits = '0, stuff_len = '0;
  logic rx_bit, sample_point, busy, done;
  logic [LW-1:0] bits_sent, stuff_inserted;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int m_tq = 0, m_bs = 0, m_si = 0;
  bit m_rx = 1, m_sp = 0, m_busy = 0, m_done = 0, m_active = 0;
  bit slots[$], kinds[$], cap[$];
  bit chk_en = 0;
  int t_first = -1, t_done = -1, n_done = 0;

  can_frame_stimulus #(.MAX_FRAME_LEN(MFL), .LEN_W(LW), .CLKS_PER_BIT(CPB), .SAMPLE_CLK(SC)) dut (
    .clock(clock), .reset(reset), .start(start), .frame_bits(frame_bits), .num_bits(num_bits),
    .stuff_en(stuff_en), .stuff_len(stuff_len), .rx_bit(rx_bit), .sample_point(sample_point),
    .busy(busy), .done(done), .bits_sent(bits_sent), .stuff_inserted(stuff_inserted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Expand a frame into its line slots (data bit / stuff bit) from the stuffing rule.
  function automatic void build(input logic [MFL-1:0] fb, input int nb, input bit se, input int sl);
    int run;
    bit prev, b;
    run = 0;
    prev = 1;
    slots.delete();
    kinds.delete();
    for (int k = 0; k < nb; k++) begin
      b = fb[nb-1-k];
      slots.push_back(b);
      kinds.push_back(0);
      if (se && k < sl) begin
        run = (run > 0 && b == prev) ? run + 1 : 1;
        prev = b;
        if (run == 5) begin
          slots.push_back(!b);
          kinds.push_back(1);
          run = 1;
          prev = !b;
        end
      end else run = 0;
    end
  endfunction

  function automatic logic [63:0] packcap();
    logic [63:0] v;
    v = '0;
    foreach (cap[i]) v = {v[62:0], cap[i]};
    return v;
  endfunction

  function automatic logic [MFL-1:0] rnd_frame();
    logic [MFL-1:0] v;
    bit b;
    b = 1'($urandom);
    for (int i = 0; i < MFL; i++) begin
      if ($urandom % 4 == 0) b = !b;
      v[i] = b;
    end
    return v;
  endfunction

  // reference model: timer, pending slot queue and counters, advanced once per clock edge
  always @(posedge clock) begin
    bit bnd, was_done;
    int nb, sl;
    cyc++;
    if (!reset) begin
      m_tq = 0; m_rx = 1; m_sp = 0; m_busy = 0; m_done = 0; m_active = 0; m_bs = 0; m_si = 0;
      slots.delete();
      kinds.delete();
    end else begin
      bnd = m_tq == CPB - 1;
      was_done = m_done;
      m_done = 0;
      m_sp = ((m_tq + 1) % CPB) == SC;
      if (m_busy && bnd) begin
        if (slots.size() == 0) begin
          m_rx = 1; m_done = 1; m_busy = 0; m_active = 0;
        end else begin
          m_rx = slots.pop_front();
          if (kinds.pop_front()) m_si++; else m_bs++;
          m_active = 1;
        end
      end else if (!m_busy && !was_done && start) begin
        nb = num_bits > MFL ? MFL : int'(num_bits);
        sl = stuff_len > MFL ? MFL : int'(stuff_len);
        build(frame_bits, nb, stuff_en, sl);
        m_busy = 1; m_bs = 0; m_si = 0;
      end
      m_tq = bnd ? 0 : m_tq + 1;
    end
  end

  // compare DUT against the model every cycle, capture decoder-side samples
  always @(negedge clock) begin
    if (chk_en) begin
      chk("rx_bit", rx_bit, m_rx);
      chk("sample_point", sample_point, m_sp);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("bits_sent", bits_sent, m_bs);
      chk("stuff_inserted", stuff_inserted, m_si);
      if (sample_point && m_active) cap.push_back(rx_bit);
      if (m_active && t_first < 0) t_first = cyc;
      if (done) begin
        t_done = cyc;
        n_done++;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 8000 && busy; i++) @(negedge clock);
    chk("wait_idle", busy, 0);
  endtask

  task automatic send(input logic [MFL-1:0] fb, input int nb, input bit se, input int sl, input bit noise, input bit hold);
    int limit;
    bit seen;
    limit = (2 * nb + 4) * CPB;
    seen = 0;
    @(negedge clock);
    frame_bits = fb; num_bits = LW'(nb); stuff_en = se; stuff_len = LW'(sl); start = 1;
    cap.delete(); t_first = -1; t_done = -1;
    @(negedge clock);
    start = 0;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clock);
      if (noise) begin
        start = ($urandom % 8 == 0);
        frame_bits = rnd_frame();
        num_bits = LW'($urandom);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    start = noise | hold;
    @(negedge clock);
    chk("not_accepted_during_done", busy, 0);
    if (hold) begin
      @(negedge clock);
      chk("accepted_after_done", busy, 1);
    end
    start = 0;
    wait_idle();
  endtask

  initial begin
    logic [MFL-1:0] f;
    int nb, sl, snap;
    bit se;
    #20000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [MFL-1:0] f;
    int nb, sl, snap;
    bit se;
    repeat (3) @(negedge clock);
    chk_en = 1;
    chk("reset_rx", rx_bit, 1);
    chk("reset_sp", sample_point, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_bits_sent", bits_sent, 0);
    chk("reset_stuff", stuff_inserted, 0);
    reset = 1;
    repeat (13) @(negedge clock);

    f = '0;
    f[44:0] = 45'b011001110010100000110000100100010011011111111;
    send(f, 45, 0, 0, 0, 0);
    chk("t45_bits_sent", bits_sent, 45);
    chk("t45_stuff", stuff_inserted, 0);
    chk("t45_slots", cap.size(), 45);
    chk("t45_line", packcap(), 64'b011001110010100000110000100100010011011111111);
    chk("t45_duration", t_done - t_first, 450);

    send('0, 8, 1, 8, 0, 0);
    chk("z8_slots", cap.size(), 9);
    chk("z8_line", packcap(), 64'b000001000);
    chk("z8_stuff", stuff_inserted, 1);
    chk("z8_bits", bits_sent, 8);

    f = '0;
    f[9:0] = 10'b1111111111;
    send(f, 10, 1, 10, 0, 0);
    chk("o10_slots", cap.size(), 12);
    chk("o10_line", packcap(), 64'b111110111110);
    chk("o10_stuff", stuff_inserted, 2);
    chk("o10_duration", t_done - t_first, 120);

    send(f, 10, 1, 3, 0, 0);
    chk("o10s3_slots", cap.size(), 10);
    chk("o10s3_line", packcap(), 64'b1111111111);
    chk("o10s3_stuff", stuff_inserted, 0);

    f = '0;
    f[9:0] = 10'b0000011110;
    send(f, 10, 1, 10, 0, 0);
    chk("run_slots", cap.size(), 12);
    chk("run_line", packcap(), 64'b000001111100);
    chk("run_stuff", stuff_inserted, 2);
    chk("run_bits", bits_sent, 10);

    send(rnd_frame(), 40, 1, 30, 1, 0);
    chk("noise_bits", bits_sent, 40);

    snap = n_done;
    send(rnd_frame(), 0, 1, 5, 0, 0);
    chk("zero_slots", cap.size(), 0);
    chk("zero_bits", bits_sent, 0);
    chk("zero_done_count", n_done, snap + 1);

    send(rnd_frame(), 6, 0, 0, 0, 1);

    @(negedge clock);
    frame_bits = rnd_frame(); num_bits = 30; stuff_en = 1; stuff_len = 20; start = 1;
    @(negedge clock);
    start = 0;
    repeat (100) @(negedge clock);
    reset = 0;
    @(negedge clock);
    chk("abort_rx", rx_bit, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    reset = 1;
    snap = n_done;
    repeat (400) @(negedge clock);
    chk("abort_no_done", n_done, snap);

    for (int t = 0; t < 25; t++) begin
      nb = $urandom_range(0, 70);
      se = 1'($urandom);
      sl = $urandom_range(0, nb + 5);
      send(rnd_frame(), nb, se, sl, 1'($urandom), 0);
      chk("rand_bits", bits_sent, nb);
      chk("rand_duration", t_done - t_first, (nb == 0) ? t_done + 1 : (nb + int'(stuff_inserted)) * CPB);
    end

    send(rnd_frame(), 1000, 1, 1000, 0, 0);
    chk("clamp_bits", bits_sent, MFL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
